mux4_arbiter: RTL and testbench



---
 rtl/mux4_arbiter_pkg.sv | 14 +
 rtl/mux4_arbiter_rr_pick4.sv | 35 +++
 rtl/mux4_arbiter.sv | 145 ++++++++++++++
 tb/tb_mux4_arbiter.sv | 134 +++++++++++++
 4 files changed

// File: rtl/mux4_arbiter_pkg.sv
// Shared definitions for the round-robin mux4 arbiter: requester count,
// index width, burst counter width and the arbiter state encoding.
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int BURST_W = 8;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage : mux4_arb_pkg

// File: rtl/mux4_arbiter_rr_pick4.sv
// Combinational round-robin picker: searches ptr+1, ptr+2, ptr+3, ptr (mod 4)
// over the request vector, optionally masking one index out of the search.
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               excl_en,
    input  logic [IDX_W-1:0]   excl_idx,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [NUM_REQ-1:0] cand;
    logic [IDX_W-1:0]   pos;

    // Mask the excluded index, then take the first set candidate after ptr.
    always_comb begin
        cand = req;
        if (excl_en) begin
            cand[excl_idx] = 1'b0;
        end
        found = 1'b0;
        idx   = ptr;
        pos   = ptr;
        for (int i = 1; i <= NUM_REQ; i++) begin
            pos = ptr + IDX_W'(i);
            if (!found && cand[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule : rr_pick4

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter owning the select line of the shared mux4_1.
// Optional burst limiting is enabled with `define MUX4_ARB_BURST_LIMIT_EN:
// an owner that has held the grant for MAX_BURST cycles is preempted when
// another requester is waiting.
//
// Output handshake: gnt is one-hot and registered; gnt_valid is high exactly
// when gnt is non-zero, and then gnt == (1 << sel). sel equals the current
// (or most recent) owner and never changes while nobody owns the mux.
module mux4_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   sel,
    output arb_state_t         dbg_state
);

    if (MAX_BURST < 2 || MAX_BURST > 255) begin : g_max_burst_range
        $error("mux4_arbiter: MAX_BURST must be in 2..255");
    end

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic                   gv_q, gv_d;
    logic                   preempt;
    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;

`ifdef MUX4_ARB_BURST_LIMIT_EN
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    logic [BURST_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     owner_mask;

    // Preempt when the burst budget is spent and someone else is waiting.
    always_comb begin
        owner_mask          = '0;
        owner_mask[owner_q] = 1'b1;
        preempt = (state_q == ARB_BUSY) && req[owner_q] &&
                  (cnt_q == BURST_LAST) && |(req & ~owner_mask);
    end
`else
    assign preempt = 1'b0;
`endif

    // The owner is only excluded from the search when it is being preempted;
    // on a release its own req is already low.
    rr_pick4 u_pick (
        .req      (req),
        .ptr      (ptr_q),
        .excl_en  (preempt),
        .excl_idx (owner_q),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    // Next-state and next-output logic; everything holds unless changed.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        gv_d    = gv_q;
`ifdef MUX4_ARB_BURST_LIMIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d         = ARB_BUSY;
                    owner_d         = pick_idx;
                    ptr_d           = pick_idx;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    gv_d            = 1'b1;
`ifdef MUX4_ARB_BURST_LIMIT_EN
                    cnt_d           = '0;
`endif
                end
            end
            ARB_BUSY: begin
                if (req[owner_q] && !preempt) begin
`ifdef MUX4_ARB_BURST_LIMIT_EN
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end else if (pick_found) begin
                    owner_d         = pick_idx;
                    ptr_d           = pick_idx;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    gv_d            = 1'b1;
`ifdef MUX4_ARB_BURST_LIMIT_EN
                    cnt_d           = '0;
`endif
                end else begin
                    state_d = ARB_IDLE;
                    gnt_d   = '0;
                    gv_d    = 1'b0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
                gv_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; ptr resets to 3 so index 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            gnt_q   <= '0;
            gv_q    <= 1'b0;
`ifdef MUX4_ARB_BURST_LIMIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            gv_q    <= gv_d;
`ifdef MUX4_ARB_BURST_LIMIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gv_q;
    assign sel       = owner_q;
    assign dbg_state = state_q;

endmodule : mux4_arbiter

// File: tb/tb_mux4_arbiter.sv
// Bench for mux4_arbiter: directed per-cycle request vectors with
// hand-computed grants pushed to an expected queue, checked by a monitor.
module tb_mux4_arbiter;
    import mux4_arb_pkg::*;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] sel;
    arb_state_t dbg_state;

    always #5 clk = ~clk;

    mux4_arbiter #(.MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .sel       (sel),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    // Expected word: {gnt[3:0], gnt_valid, sel[1:0], busy}
    logic [W-1:0] exp_q[$];
    int           tests = 0;
    int           fails = 0;
    int           stepno = 0;
    logic [W-1:0] exp_w;
    logic [W-1:0] act_w;

    // ---------------- driver ----------------
    // Drive rst/req for one cycle and queue the outputs expected after the edge.
    task automatic step(input logic r, input logic [3:0] rq,
                        input logic [3:0] eg, input logic [1:0] es);
        @(negedge clk);
        rst = r;
        req = rq;
        exp_q.push_back({eg, |eg, es, |eg});
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                act_w = {gnt, gnt_valid, sel, dbg_state == ARB_BUSY};
                tests++;
                stepno++;
                if (act_w !== exp_w) begin
                    fails++;
                    $display("FAIL arb_out step %0d: got gnt=%b gnt_valid=%b sel=%0d busy=%b, want gnt=%b gnt_valid=%b sel=%0d busy=%b",
                             stepno, act_w[7:4], act_w[3], act_w[2:1], act_w[0],
                             exp_w[7:4], exp_w[3], exp_w[2:1], exp_w[0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        step(1, 4'b0000, 4'b0000, 2'd0);
        step(1, 4'b0000, 4'b0000, 2'd0);

        // Single request from reset: index 0 wins with 1-cycle latency
        step(0, 4'b0001, 4'b0001, 2'd0);
        step(0, 4'b0000, 4'b0000, 2'd0);

        // All requesting; each owner drops for one cycle -> 0,1,2,3,0, no gaps
        step(1, 4'b0000, 4'b0000, 2'd0);
        step(0, 4'b1111, 4'b0001, 2'd0);
        step(0, 4'b1110, 4'b0010, 2'd1);
        step(0, 4'b1111, 4'b0010, 2'd1);
        step(0, 4'b1101, 4'b0100, 2'd2);
        step(0, 4'b1111, 4'b0100, 2'd2);
        step(0, 4'b1011, 4'b1000, 2'd3);
        step(0, 4'b1111, 4'b1000, 2'd3);
        step(0, 4'b0111, 4'b0001, 2'd0);

        // Owner 0 releases, 2 takes over; then 2 releases to idle, sel holds 2
        step(0, 4'b0100, 4'b0100, 2'd2);
        step(0, 4'b0100, 4'b0100, 2'd2);
        step(0, 4'b0000, 4'b0000, 2'd2);
        step(0, 4'b0000, 4'b0000, 2'd2);

        // From ptr=2, req 0010 -> 1; reset mid-ownership; re-arbitrate from ptr=3
        step(0, 4'b0010, 4'b0010, 2'd1);
        step(0, 4'b0110, 4'b0010, 2'd1);
        step(1, 4'b0110, 4'b0000, 2'd0);
        step(0, 4'b0110, 4'b0010, 2'd1);

        // Release with simultaneous new requests, then wrap-around to 0
        step(0, 4'b1001, 4'b1000, 2'd3);
        step(0, 4'b0001, 4'b0001, 2'd0);
        step(0, 4'b0000, 4'b0000, 2'd0);

        step(1, 4'b0000, 4'b0000, 2'd0);
`ifdef MUX4_ARB_BURST_LIMIT_EN
        // Burst limit 4: 0 holds 4 cycles, 1 holds 4 cycles, back to 0
        for (int i = 0; i < 4; i++) step(0, 4'b0011, 4'b0001, 2'd0);
        for (int i = 0; i < 4; i++) step(0, 4'b0011, 4'b0010, 2'd1);
        step(0, 4'b0011, 4'b0001, 2'd0);
        // Lone requester is never preempted
        for (int i = 0; i < 12; i++) step(0, 4'b0001, 4'b0001, 2'd0);
`else
        // No burst limit: a waiting requester never disturbs the owner
        for (int i = 0; i < 100; i++) step(0, 4'b0011, 4'b0001, 2'd0);
`endif
        step(0, 4'b0000, 4'b0000, 2'd0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #2;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_mux4_arbiter
